// File: rtl/eq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eq_pkg
// Purpose  : Shared FSM encoding and default sizing for the equalizer sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package eq_pkg;

    localparam int c_cnt_width  = 6;
    localparam int c_num_phases = 64;
    localparam int c_num_ch     = 8;
    localparam int c_ch_width   = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : eq_pkg
`default_nettype wire

// File: rtl/phase_counter.sv
`default_nettype none
// ============================================================================
// Module   : phase_counter
// Purpose  : Modulo-NUM_PHASES counter with enable, synchronous clear and a
//            terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module phase_counter
    import eq_pkg::*;
#(
    parameter int CNT_WIDTH  = c_cnt_width,
    parameter int NUM_PHASES = c_num_phases
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 terminal
);

    localparam logic [CNT_WIDTH-1:0] c_last = CNT_WIDTH'(NUM_PHASES - 1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_terminal;

    // Wrap comes from the compare so NUM_PHASES below 2^CNT_WIDTH works too.
    assign w_terminal = (r_count == c_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_terminal ? '0 : r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = w_terminal;

endmodule : phase_counter
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : phase_sequencer
// Purpose  : Sequences NUM_CH channels of NUM_PHASES phases per input sample
//            and emits phase strobes, channel index and frame-done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module phase_sequencer
    import eq_pkg::*;
#(
    parameter int CNT_WIDTH  = c_cnt_width,
    parameter int NUM_PHASES = c_num_phases,
    parameter int NUM_CH     = c_num_ch,
    parameter int CH_WIDTH   = c_ch_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_enable,
    input  logic                 sample_valid,
    output logic                 ready,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] current_count,
    output logic [CH_WIDTH-1:0]  channel,
    output logic                 phase_first,
    output logic                 phase_last,
    output logic                 control_phase_bar,
    output logic                 frame_done,
    output logic                 overrun
);

    localparam logic [CH_WIDTH-1:0] c_last_ch = CH_WIDTH'(NUM_CH - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CH_WIDTH-1:0]  r_channel;
    logic                 r_frame_done;
    logic                 r_overrun;
    logic [CNT_WIDTH-1:0] w_count;
    logic                 w_terminal;
    logic                 w_run;
    logic                 w_adv;
    logic                 w_frame_end;

    assign w_run       = (r_state == ST_RUN);
    assign w_adv       = w_run && clk_enable;
    assign w_frame_end = w_adv && w_terminal && (r_channel == c_last_ch);

    // Held in clear while idle so every frame starts from phase 0.
    phase_counter #(
        .CNT_WIDTH  (CNT_WIDTH),
        .NUM_PHASES (NUM_PHASES)
    ) u_phase_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (!w_run),
        .enable   (w_adv),
        .count    (w_count),
        .terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (sample_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_frame_end)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_channel <= '0;
        end else if (w_adv && w_terminal) begin
            r_channel <= (r_channel == c_last_ch) ? '0 : r_channel + 1'b1;
        end
    end

    // A start request during a frame is dropped but remembered until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_run && sample_valid) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign ready             = !w_run;
    assign busy              = w_run;
    assign current_count     = w_count;
    assign channel           = r_channel;
    assign phase_first       = w_adv && (w_count == '0);
    assign phase_last        = w_adv && w_terminal;
    assign control_phase_bar = !phase_last;
    assign frame_done        = r_frame_done;
    assign overrun           = r_overrun;

endmodule : phase_sequencer
`default_nettype wire

// File: tb/tb_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_sequencer
// Purpose  : Self-checking bench for phase_sequencer (default and 4x2 sizing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-sized instance
    logic       rst_a, en_a, sv_a;
    logic       ready_a, busy_a, first_a, last_a, cpb_a, fd_a, ovr_a;
    logic [5:0] cnt_a;
    logic [2:0] ch_a;

    // Small instance: 4 phases (== 2^CNT_WIDTH), 2 channels
    logic       rst_b, en_b, sv_b;
    logic       ready_b, busy_b, first_b, last_b, cpb_b, fd_b, ovr_b;
    logic [1:0] cnt_b;
    logic [0:0] ch_b;

    int n_checks = 0;
    int n_fail   = 0;

    phase_sequencer u_dut_a (
        .clk               (clk),
        .rst               (rst_a),
        .clk_enable        (en_a),
        .sample_valid      (sv_a),
        .ready             (ready_a),
        .busy              (busy_a),
        .current_count     (cnt_a),
        .channel           (ch_a),
        .phase_first       (first_a),
        .phase_last        (last_a),
        .control_phase_bar (cpb_a),
        .frame_done        (fd_a),
        .overrun           (ovr_a)
    );

    phase_sequencer #(
        .CNT_WIDTH  (2),
        .NUM_PHASES (4),
        .NUM_CH     (2),
        .CH_WIDTH   (1)
    ) u_dut_b (
        .clk               (clk),
        .rst               (rst_b),
        .clk_enable        (en_b),
        .sample_valid      (sv_b),
        .ready             (ready_b),
        .busy              (busy_b),
        .current_count     (cnt_b),
        .channel           (ch_b),
        .phase_first       (first_b),
        .phase_last        (last_b),
        .control_phase_bar (cpb_b),
        .frame_done        (fd_b),
        .overrun           (ovr_b)
    );

    typedef struct packed {
        logic       rst, en, sv;
        logic       rdy;
        logic [1:0] cnt;
        logic       ch;
        logic       first, last, fd, ovr;
    } vec_t;

    vec_t        tbl [30];
    logic [15:0] exp_q [$];

    function automatic vec_t mkv(input logic r, input logic e, input logic s,
                                 input logic rdy, input int cnt, input int ch,
                                 input logic f, input logic l, input logic fd,
                                 input logic ov);
        vec_t v;
        v = '{rst: r, en: e, sv: s, rdy: rdy, cnt: 2'(cnt), ch: 1'(ch),
              first: f, last: l, fd: fd, ovr: ov};
        return v;
    endfunction

    function automatic logic [15:0] exp_b(input vec_t v);
        return {6'd0, v.rdy, ~v.rdy, v.cnt, v.ch, v.first, v.last, ~v.last, v.fd, v.ovr};
    endfunction

    function automatic logic [15:0] act_b();
        return {6'd0, ready_b, busy_b, cnt_b, ch_b, first_b, last_b, cpb_b, fd_b, ovr_b};
    endfunction

    function automatic logic [15:0] exp_a(input logic rdy, input int cnt, input int ch,
                                          input logic f, input logic l, input logic fd,
                                          input logic ov);
        return {rdy, ~rdy, 6'(cnt), 3'(ch), f, l, ~l, fd, ov};
    endfunction

    function automatic logic [15:0] act_a();
        return {ready_a, busy_a, cnt_a, ch_a, first_a, last_a, cpb_a, fd_a, ovr_a};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One frame on the default instance; optional sample_valid / rst at a
    // given enabled-cycle index (-1 = none).
    task automatic run_a(input int sv_at, input int rst_at, input logic ovr_in, input string tag);
        logic ovr_e;
        ovr_e = ovr_in;
        @(negedge clk);
        sv_a = 1'b1; en_a = 1'b0; rst_a = 1'b0;
        #1 check($sformatf("%s_start", tag), act_a(), exp_a(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, ovr_e));
        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            sv_a = (i == sv_at); rst_a = (i == rst_at); en_a = 1'b1;
            #1 check($sformatf("%s_cyc%0d", tag, i), act_a(),
                     exp_a(1'b0, i % 64, i / 64, (i % 64) == 0, (i % 64) == 63, 1'b0, ovr_e));
            if (i == sv_at) ovr_e = 1'b1;
            if (i == rst_at) break;
        end
        @(negedge clk);
        sv_a = 1'b0; rst_a = 1'b0; en_a = 1'b1;
        if (rst_at >= 0) begin
            #1 check($sformatf("%s_abort", tag), act_a(), exp_a(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        end else begin
            #1 check($sformatf("%s_done", tag), act_a(), exp_a(1'b1, 0, 0, 1'b0, 1'b0, 1'b1, ovr_e));
        end
        @(negedge clk);
        #1 check($sformatf("%s_idle", tag), act_a(),
                 exp_a(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, (rst_at >= 0) ? 1'b0 : ovr_e));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b1; sv_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1; sv_b = 1'b1;

        // Reset held for two edges, with enable and start asserted
        repeat (2) @(negedge clk);
        #1;
        check("reset_a", act_a(), exp_a(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("reset_b", act_b(), exp_b(mkv(1, 1, 1, 1, 0, 0, 0, 0, 0, 0)));
        rst_a = 1'b0; sv_a = 1'b0;

        //            rst en sv | rdy cnt ch first last fd ovr
        tbl[0]  = mkv(0, 1, 0,   1,  0,  0,  0,   0,   0, 0);
        tbl[1]  = mkv(0, 0, 1,   1,  0,  0,  0,   0,   0, 0);
        tbl[2]  = mkv(0, 1, 0,   0,  0,  0,  1,   0,   0, 0);
        tbl[3]  = mkv(0, 0, 0,   0,  1,  0,  0,   0,   0, 0);
        tbl[4]  = mkv(0, 1, 0,   0,  1,  0,  0,   0,   0, 0);
        tbl[5]  = mkv(0, 0, 0,   0,  2,  0,  0,   0,   0, 0);
        tbl[6]  = mkv(0, 1, 0,   0,  2,  0,  0,   0,   0, 0);
        tbl[7]  = mkv(0, 0, 0,   0,  3,  0,  0,   0,   0, 0);
        tbl[8]  = mkv(0, 1, 0,   0,  3,  0,  0,   1,   0, 0);
        tbl[9]  = mkv(0, 0, 0,   0,  0,  1,  0,   0,   0, 0);
        tbl[10] = mkv(0, 1, 0,   0,  0,  1,  1,   0,   0, 0);
        tbl[11] = mkv(0, 0, 0,   0,  1,  1,  0,   0,   0, 0);
        tbl[12] = mkv(0, 1, 0,   0,  1,  1,  0,   0,   0, 0);
        tbl[13] = mkv(0, 0, 0,   0,  2,  1,  0,   0,   0, 0);
        tbl[14] = mkv(0, 1, 0,   0,  2,  1,  0,   0,   0, 0);
        tbl[15] = mkv(0, 0, 0,   0,  3,  1,  0,   0,   0, 0);
        tbl[16] = mkv(0, 1, 0,   0,  3,  1,  0,   1,   0, 0);
        tbl[17] = mkv(0, 1, 1,   1,  0,  0,  0,   0,   1, 0);
        tbl[18] = mkv(0, 1, 0,   0,  0,  0,  1,   0,   0, 0);
        tbl[19] = mkv(0, 1, 0,   0,  1,  0,  0,   0,   0, 0);
        tbl[20] = mkv(0, 1, 0,   0,  2,  0,  0,   0,   0, 0);
        tbl[21] = mkv(0, 1, 0,   0,  3,  0,  0,   1,   0, 0);
        tbl[22] = mkv(0, 1, 1,   0,  0,  1,  1,   0,   0, 0);
        tbl[23] = mkv(0, 1, 0,   0,  1,  1,  0,   0,   0, 1);
        tbl[24] = mkv(0, 1, 0,   0,  2,  1,  0,   0,   0, 1);
        tbl[25] = mkv(0, 1, 1,   0,  3,  1,  0,   1,   0, 1);
        tbl[26] = mkv(0, 0, 0,   1,  0,  0,  0,   0,   1, 1);
        tbl[27] = mkv(0, 0, 0,   1,  0,  0,  0,   0,   0, 1);
        tbl[28] = mkv(1, 0, 0,   1,  0,  0,  0,   0,   0, 1);
        tbl[29] = mkv(0, 0, 0,   1,  0,  0,  0,   0,   0, 0);

        // Scoreboard: expected vector queued as stimulus is driven
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            rst_b = tbl[k].rst; en_b = tbl[k].en; sv_b = tbl[k].sv;
            exp_q.push_back(exp_b(tbl[k]));
            #1;
            check($sformatf("small_vec%0d", k), act_b(), exp_q.pop_front());
        end

        run_a(-1,  -1, 1'b0, "full_frame");
        run_a(202, -1, 1'b0, "overrun");
        run_a(-1, 340, 1'b1, "abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_phase_sequencer
`default_nettype wire
